mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one memory port between the core's instruction-fetch and data (load/store) requesters.
//  Round-robin arbitration; one outstanding transaction at a time, held in registers.
//  Every accepted request gets exactly one response routed back to its owner.
//  Sits between the core's instr/data master interfaces and a single unified memory.
// PARAMETERS
//  ADDR_W          32   address width (matches `ADDRWIDTH)
//  DATA_W          32   data width (matches `BUSWIDTH)
//  TIMEOUT_CYCLES  64   WAIT-state cycle limit; used only when ARB_TIMEOUT_EN is defined; must be >=1
// PORTS
//  clk            in   1       clock, all state on rising edge
//  cpu_rstn       in   1       reset, asynchronous, active-low
//  ireq_valid     in   1       fetch request valid
//  ireq_ready     out  1       fetch request accepted this cycle
//  ireq_addr      in   ADDR_W  fetch address
//  irsp_valid     out  1       fetch response, one-cycle pulse
//  irsp_data      out  DATA_W  fetch read data
//  irsp_err       out  1       fetch response is a timeout error
//  dreq_valid     in   1       data request valid
//  dreq_ready     out  1       data request accepted this cycle
//  dreq_we        in   1       1 = store, 0 = load
//  dreq_addr      in   ADDR_W  data address
//  dreq_wdata     in   DATA_W  store data
//  drsp_valid     out  1       data response, one-cycle pulse (loads and stores)
//  drsp_data      out  DATA_W  load data (stores: memory's rdata passed through)
//  drsp_err       out  1       data response is a timeout error
//  mem_req_valid  out  1       memory request valid
//  mem_req_ready  in   1       memory accepts request
//  mem_we         out  1       memory write enable
//  mem_addr       out  ADDR_W  memory address
//  mem_wdata      out  DATA_W  memory write data
//  mem_rsp_valid  in   1       memory response valid
//  mem_rdata      in   DATA_W  memory read data
// BEHAVIOUR
//  - Reset: state=IDLE, last_grant=DATA, all outputs 0, holding regs 0.
//  - FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: pick a winner. If only one requester is valid, it wins. If both are valid, the one
//    not in last_grant wins. Assert the winner's *req_ready for exactly that cycle.
//    On the same edge: latch owner/we/addr/wdata, go to ISSUE. Fetch requests force we=0.
//  - *req_ready is 0 in every state except IDLE. Never assert both readies in the same cycle.
//  - ISSUE: mem_req_valid=1 driven from holding regs. Hold it until mem_req_ready=1, then go to WAIT.
//    Address and data stay stable while valid is high.
//  - WAIT: on mem_rsp_valid, capture mem_rdata, err=0, go to RESP.
//    mem_rsp_valid in any other state is ignored.
//  - RESP: owner's *rsp_valid=1 for one cycle with the captured data/err; the other rsp_valid stays 0.
//    Set last_grant=owner, go to IDLE.
//  - Latency: accept at T, mem_req_valid at T+1, and with ready=1 and mem response at T+2,
//    rsp_valid at T+3. Next accept at T+4 at the earliest.
//  - *rsp_data is 0 when *rsp_valid is 0. No combinational path from requester inputs to mem_* outputs.
//  - A requester dropping valid before ready has no effect; nothing is latched.
//  - Reset mid-transaction returns everything to the reset state. The memory-side transaction is
//    abandoned and its late response (seen in IDLE) is dropped.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//    - Counter clears on entry to WAIT and increments each WAIT cycle.
//    - When it reaches TIMEOUT_CYCLES with no mem_rsp_valid: go to RESP with err=1 and data=0.
//    - mem_rsp_valid in the same cycle as expiry wins (normal response, err=0).
//  ARB_TIMEOUT_EN undefined:
//    - No counter. WAIT holds until mem_rsp_valid.
//    - irsp_err and drsp_err are tied to 0.
// TESTING
//  1 Fetch only: ireq addr=0x100, mem rdata=0x00000013 at T+2 -> irsp_valid at T+3, data=0x13, err=0.
//  2 Both valid after reset -> fetch granted first, data second, then fetch again (alternates).
//    ireq_ready and dreq_ready never high together.
//  3 Store: dreq we=1 addr=0x2000 wdata=0xCAFEF00D, mem_req_ready held low 5 cycles ->
//    mem_* stable for those 5 cycles, one drsp_valid pulse, no irsp.
//  4 cpu_rstn low during WAIT, then mem_rsp_valid arrives after reset release ->
//    no rsp pulse, all outputs 0, state IDLE.
//  5 [ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4] mem never responds -> drsp_valid with err=1, data=0 after
//    4 WAIT cycles; next request is served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction-fetch and data requesters.
// Optional WAIT-state timeout enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              cpu_rstn,
    input  logic              ireq_valid,
    output logic              ireq_ready,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              irsp_valid,
    output logic [DATA_W-1:0] irsp_data,
    output logic              irsp_err,
    input  logic              dreq_valid,
    output logic              dreq_ready,
    input  logic              dreq_we,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [DATA_W-1:0] dreq_wdata,
    output logic              drsp_valid,
    output logic [DATA_W-1:0] drsp_data,
    output logic              drsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    state_t            state, state_nx;
    owner_t            owner_q, last_grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              grant_i, grant_d;
    logic              expire;

    always_comb begin
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (ireq_valid && dreq_valid) begin
                    grant_i = (last_grant == OWN_DATA);
                    grant_d = (last_grant == OWN_FETCH);
                end else begin
                    grant_i = ireq_valid;
                    grant_d = dreq_valid;
                end
                if (grant_i || grant_d) state_nx = S_ISSUE;
            end
            S_ISSUE: if (mem_req_ready) state_nx = S_WAIT;
            S_WAIT:  if (mem_rsp_valid || expire) state_nx = S_RESP;
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state      <= S_IDLE;
            owner_q    <= OWN_FETCH;
            last_grant <= OWN_DATA;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (grant_i || grant_d) begin
                    owner_q <= grant_d ? OWN_DATA : OWN_FETCH;
                    we_q    <= grant_d & dreq_we;
                    addr_q  <= grant_d ? dreq_addr : ireq_addr;
                    wdata_q <= grant_d ? dreq_wdata : '0;
                end
                S_WAIT: begin
                    if (mem_rsp_valid)  rdata_q <= mem_rdata;
                    else if (expire)    rdata_q <= '0;
                end
                S_RESP:  last_grant <= owner_q;
                default: ;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tcnt;
    logic             err_q;

    // tcnt holds the number of WAIT cycles already elapsed, so expiry lands on the last allowed one
    assign expire = (state == S_WAIT) && !mem_rsp_valid && (tcnt == CNT_MAX);

    always_ff @(posedge clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == S_ISSUE && mem_req_ready) tcnt <= '0;
            else if (state == S_WAIT)              tcnt <= tcnt + 1'b1;
            if (state == S_WAIT && mem_rsp_valid)  err_q <= 1'b0;
            else if (expire)                       err_q <= 1'b1;
        end
    end

    assign irsp_err = irsp_valid & err_q;
    assign drsp_err = drsp_valid & err_q;
`else
    assign expire   = 1'b0;
    assign irsp_err = 1'b0;
    assign drsp_err = 1'b0;
`endif

    assign ireq_ready    = grant_i;
    assign dreq_ready    = grant_d;

    assign mem_req_valid = (state == S_ISSUE);
    assign mem_we        = mem_req_valid & we_q;
    assign mem_addr      = mem_req_valid ? addr_q  : '0;
    assign mem_wdata     = mem_req_valid ? wdata_q : '0;

    assign irsp_valid    = (state == S_RESP) && (owner_q == OWN_FETCH);
    assign drsp_valid    = (state == S_RESP) && (owner_q == OWN_DATA);
    assign irsp_data     = irsp_valid ? rdata_q : '0;
    assign drsp_data     = drsp_valid ? rdata_q : '0;

endmodule
